// File: rtl/memory_arbiter.sv
// Shares one memory controller between fetch and data: grants are combinational, the address phase is registered and read data returns one cycle later.
// Requesters hold their request until granted; data wins unless fetch has waited MAX_DATA_STREAK data grants.
module memory_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_abort,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_write,
  input  logic [1:0]        d_size,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_abort,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic [1:0]        mem_prot,
  output logic [1:0]        mem_trans,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_abort
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef struct packed {
    logic vld;
    logic own_d;
    logic wr;
  } tag_t;

  logic [SW-1:0] streak;
  logic          at_limit;
  logic          addr_phase;
  logic          d_seq;
  logic          i_seq;
  tag_t          tag_a;
  tag_t          tag_r;

  assign at_limit   = (streak == SW'(MAX_DATA_STREAK));
  assign d_gnt      = d_req && !(i_req && at_limit);
  assign i_gnt      = i_req && !flush && !d_gnt;

  // mem_prot[0] identifies the owner of the current address phase
  assign addr_phase = (mem_trans != 2'b00);
  assign d_seq      = addr_phase && mem_prot[0] && (mem_write == d_write) &&
                      (d_addr == mem_addr + ADDR_W'(1));
  assign i_seq      = addr_phase && !mem_prot[0] && !mem_write &&
                      (i_addr == mem_addr + ADDR_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak    <= '0;
      tag_a     <= '0;
      tag_r     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_size  <= 2'b10;
      mem_prot  <= 2'b10;
      mem_trans <= 2'b00;
    end else begin
      if (i_gnt || !i_req)
        streak <= '0;
      else if (d_gnt && !at_limit)
        streak <= streak + SW'(1);

      tag_a <= '{vld: (i_gnt || d_gnt), own_d: d_gnt, wr: (d_gnt && d_write)};
      // a flush kills the fetch still in its address phase before it can return
      tag_r <= tag_a;
      if (flush && !tag_a.own_d)
        tag_r.vld <= 1'b0;

      if (d_gnt) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_write <= d_write;
        mem_size  <= d_size;
        mem_prot  <= 2'b11;
        mem_trans <= d_seq ? 2'b11 : 2'b10;
      end else if (i_gnt) begin
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_write <= 1'b0;
        mem_size  <= 2'b10;
        mem_prot  <= 2'b10;
        mem_trans <= i_seq ? 2'b11 : 2'b10;
      end else begin
        mem_write <= 1'b0;
        mem_trans <= 2'b00;
      end
    end
  end

  assign i_rvalid = tag_r.vld && !tag_r.own_d && !flush;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign i_abort  = i_rvalid && mem_abort;
  assign d_done   = tag_r.vld && tag_r.own_d;
  assign d_rdata  = (d_done && !tag_r.wr) ? mem_rdata : '0;
  assign d_abort  = d_done && mem_abort;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then random traffic, checked against a queue-based reference model.
module tb_memory_arbiter;

  localparam int MAXS = 4;
  localparam logic [31:0] ABORT_BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid, i_abort;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_write = 1'b0;
  logic [1:0]  d_size = 2'b10;
  logic        d_gnt, d_done, d_abort;
  logic [31:0] d_rdata;
  logic        flush = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_write;
  logic [1:0]  mem_size, mem_prot, mem_trans;
  logic [31:0] mem_rdata = '0;
  logic        mem_abort = 1'b0;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_abort(i_abort),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
    .d_size(d_size), .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .d_abort(d_abort), .flush(flush),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_size(mem_size), .mem_prot(mem_prot), .mem_trans(mem_trans),
    .mem_rdata(mem_rdata), .mem_abort(mem_abort)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // Memory device behind the controller
  logic [31:0] dev_mem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_trans != 2'b00) begin
      if (mem_write) begin
        dev_mem[mem_addr] = mem_wdata;
        mem_rdata <= 32'h0BAD_F00D;
      end else begin
        mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);
      end
      mem_abort <= (mem_addr >= ABORT_BASE);
    end else begin
      mem_rdata <= '0;
      mem_abort <= 1'b0;
    end
  end

  // Reference model
  typedef struct {
    int          due;
    bit          own_d;
    bit          wr;
    logic [31:0] data;
    bit          abt;
  } resp_t;

  typedef struct {
    bit          vld;
    bit          own_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [1:0]  trans;
  } ap_t;

  logic [31:0] ref_mem [logic [31:0]];
  resp_t pend[$];
  ap_t   ap_cur;
  int    cyc = 0;
  int    streak_m = 0;
  int    checks = 0;
  int    passed = 0;
  int    fails = 0;
  string gnt_log = "";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(output bit gd, output bit gi);
    bit    eg_d, eg_i, have;
    resp_t r;
    ap_t   nap;
    @(negedge clk);
    eg_d = d_req && !(i_req && streak_m == MAXS);
    eg_i = !eg_d && i_req && !flush;
    chk("d_gnt", d_gnt, eg_d);
    chk("i_gnt", i_gnt, eg_i);
    if (d_gnt) gnt_log = {gnt_log, "D"};
    if (i_gnt) gnt_log = {gnt_log, "I"};

    chk("mem_trans", mem_trans, ap_cur.vld ? ap_cur.trans : 2'b00);
    chk("mem_write", mem_write, ap_cur.vld && ap_cur.wr);
    if (ap_cur.vld) begin
      chk("mem_addr", mem_addr, ap_cur.addr);
      chk("mem_prot", mem_prot, ap_cur.own_d ? 2'b11 : 2'b10);
      chk("mem_size", mem_size, ap_cur.size);
      if (ap_cur.wr) chk("mem_wdata", mem_wdata, ap_cur.wdata);
    end

    if (flush)
      for (int j = pend.size() - 1; j >= 0; j--)
        if (!pend[j].own_d) pend.delete(j);
    have = (pend.size() > 0) && (pend[0].due == cyc);
    if (have) r = pend.pop_front();
    chk("i_rvalid", i_rvalid, have && !r.own_d);
    chk("d_done", d_done, have && r.own_d);
    if (have && !r.own_d) begin
      chk("i_rdata", i_rdata, r.data);
      chk("i_abort", i_abort, r.abt);
    end
    if (have && r.own_d) begin
      chk("d_rdata", d_rdata, r.wr ? 32'h0 : r.data);
      chk("d_abort", d_abort, r.abt);
    end

    nap = '{default: '0};
    if (eg_d || eg_i) begin
      nap.vld   = 1'b1;
      nap.own_d = eg_d;
      nap.wr    = eg_d && d_write;
      nap.addr  = eg_d ? d_addr : i_addr;
      nap.wdata = d_wdata;
      nap.size  = eg_d ? d_size : 2'b10;
      nap.trans = (ap_cur.vld && ap_cur.own_d == nap.own_d && ap_cur.wr == nap.wr &&
                   nap.addr == ap_cur.addr + 32'd1) ? 2'b11 : 2'b10;
      r.due   = cyc + 2;
      r.own_d = nap.own_d;
      r.wr    = nap.wr;
      r.abt   = (nap.addr >= ABORT_BASE);
      if (nap.wr) begin
        ref_mem[nap.addr] = nap.wdata;
        r.data = '0;
      end else begin
        r.data = ref_mem.exists(nap.addr) ? ref_mem[nap.addr] : init_val(nap.addr);
      end
      pend.push_back(r);
    end
    if (eg_i || !i_req) streak_m = 0;
    else if (eg_d && streak_m < MAXS) streak_m++;
    ap_cur = nap;
    gd = eg_d;
    gi = eg_i;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_mem_trans", mem_trans, 2'b00);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_size", mem_size, 2'b10);
    chk("rst_mem_prot", mem_prot, 2'b10);
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_d_done", d_done, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_i_abort", i_abort, 1'b0);
    chk("rst_d_abort", d_abort, 1'b0);
    pend.delete();
    streak_m = 0;
    ap_cur = '{default: '0};
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit gd, gi;
    i_req = 1'b0;
    d_req = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < n; k++) tick(gd, gi);
  endtask

  function automatic logic [31:0] pick(input logic [31:0] a);
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return a + 32'd1;
    if (r < 8) return 32'($urandom_range(0, 255));
    return ABORT_BASE + 32'($urandom_range(0, 255));
  endfunction

  initial begin
    bit gd, gi;
    ap_cur = '{default: '0};
    do_reset();

    // single fetch
    i_req = 1'b1; i_addr = 32'h10;
    tick(gd, gi);
    idle(3);

    // sequential fetch burst
    i_req = 1'b1; i_addr = 32'h20;
    for (int k = 0; k < 3; k++) begin
      tick(gd, gi);
      i_addr = i_addr + 32'd1;
    end
    idle(4);

    // streak limit under sustained contention
    gnt_log = "";
    i_req = 1'b1; i_addr = 32'h60;
    d_req = 1'b1; d_addr = 32'h80; d_write = 1'b0; d_size = 2'b10;
    for (int k = 0; k < 10; k++) begin
      tick(gd, gi);
      if (gd) d_addr = d_addr + 32'd1;
      if (gi) i_addr = i_addr + 32'd1;
    end
    chk("grant_order", gnt_log == "DDDDIDDDDI", 1'b1);
    idle(3);

    // store then load of the same word
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_size = 2'b10;
    tick(gd, gi);
    d_write = 1'b0;
    tick(gd, gi);
    idle(3);

    // flush discards in-flight fetches
    i_req = 1'b1; i_addr = 32'h30;
    tick(gd, gi);
    i_addr = 32'h31;
    tick(gd, gi);
    i_addr = 32'h50; flush = 1'b1;
    tick(gd, gi);
    flush = 1'b0;
    tick(gd, gi);
    idle(3);

    // reset during a load's address phase
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h44;
    tick(gd, gi);
    d_req = 1'b0;
    do_reset();
    idle(3);

    // aborting fetch and address wrap-around staying sequential
    i_req = 1'b1; i_addr = 32'hFFFF_FFFF;
    tick(gd, gi);
    i_addr = 32'h0;
    tick(gd, gi);
    idle(3);

    // random traffic
    gd = 1'b0; gi = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!i_req || gi) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = pick(i_addr);
      end
      if (!d_req || gd) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_addr  = pick(d_addr);
        d_write = $urandom_range(0, 1) != 0;
        d_wdata = $urandom;
        d_size  = 2'($urandom_range(0, 3));
      end
      flush = ($urandom_range(0, 7) == 0);
      tick(gd, gi);
    end
    idle(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
